nios_rs232_rx: RTL and testbench
================================

# nios_rs232_rx

RS-232 serial receiver exposed as a zero-wait-state Avalon-MM slave on the Nios system bus, the receive-side counterpart to the RS-232 transmit PIO. Oversamples the asynchronous `rxd` line with a clock-divided bit timer, deserialises 8N1 frames LSB-first, and buffers received bytes in a small FIFO. Software reads bytes and status through registers; an optional level interrupt signals pending data or errors.

## Interface
- `CLKS_PER_BIT`, 434, clocks per serial bit, 115200 baud at 50 MHz; minimum 8.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, 2..16.

- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
- `chipselect`  in  1  slave select.
- `read_n`  in  1  active-low read strobe; one cycle per access.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read data; unused bits 0.
- `rxd`  in  1  asynchronous serial input; idle high.
- `irq`  out  1  level interrupt.

## Operation
- **Synchroniser:** 2-FF on `rxd`, both stages reset to 1. `rx_s` is the synchronised value; `rx_prev` is its one-cycle delay, reset 1.
- **FSM states:** IDLE, START, DATA, STOP. Reset state is IDLE.
  - IDLE: on `rx_prev`=1 and `rx_s`=0, go to START and load the bit timer with `CLKS_PER_BIT/2 - 1`.
  - START: at timer zero, sample `rx_s`. If 1, treat as a glitch and return to IDLE. If 0, go to DATA with the timer at `CLKS_PER_BIT - 1` and bit index 0.
  - DATA: at each timer zero, shift `rx_s` into `shift[bit_idx]` (LSB first) and reload the timer. After bit 7, go to STOP.
  - STOP: at timer zero, sample `rx_s`. If 1, push `shift` to the FIFO. If 0, set `ferr`, discard the byte, and return to IDLE. IDLE then needs a fresh high-to-low edge, so a held break does not retrigger.
- **FIFO:** `FIFO_DEPTH` x 8, with a count of width `$clog2(FIFO_DEPTH)+1`.
  - A push when full drops the byte and sets `ovr`.
  - A push and pop in the same cycle while full both succeed; `ovr` is not set.
  - A pop when empty does nothing.
- **Registers:**
  - DATA (addr 0), read: `{24'b0, fifo_head}`, or 0 when empty. A read with `chipselect & ~read_n` pops the FIFO. Writes are ignored.
  - STATUS (addr 1), read:
    - bit0 `rx_valid` (FIFO not empty)
    - bit1 `ovr`
    - bit2 `ferr`
    - bit3 `busy` (FSM not IDLE)
    - bits[8:4] FIFO count
    - other bits 0
  - STATUS write: write-1-to-clear on bits 1 and 2. If an error event and a clear occur in the same cycle, the set wins.
  - CONTROL (addr 2), read/write: bit0 `irq_en`, reset 0.
  - Reserved (addr 3): reads 0, writes ignored.
- `irq = irq_en & (rx_valid | ovr | ferr)`.
- **Reset mid-frame:** asserting `reset_n` mid-frame aborts the frame. The FIFO empties and all flags clear.

## Timing
- **Reset values:**
  - `readdata` reflects cleared state; STATUS reads 0.
  - `irq` = 0.
  - Synchroniser and `rx_prev` = 1, FSM = IDLE, FIFO empty, `ovr` = `ferr` = `irq_en` = 0.
- **Input latency:** the `rxd` falling edge reaches `rx_s` 2 clocks later; the start edge is detected in that cycle.
- **Sample points:**
  - Start-bit sample at detect + `CLKS_PER_BIT/2`.
  - Data bit n sample at detect + `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`.
  - Stop-bit sample at detect + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- **Output latency:** the FIFO write is registered at the stop-sample edge. `rx_valid`, `readdata` and `irq` update the next cycle.
- **Bus reads:** combinational, zero wait states. The pop takes effect at the clock edge ending the read cycle, and the next read sees the following byte.
- A new start edge is accepted from the cycle after the STOP decision, so back-to-back frames with a single stop bit are received.

## Structure
- **Package `nios_rs232_rx_pkg`:**
  - register address constants
  - STATUS bit positions
  - FSM state enum
- **Sub-module `nios_rs232_rx_fifo`:** synchronous FIFO with push/pop/full/empty/count, parameterised on depth and width 8.
- **Top level:** synchroniser, bit timer, FSM, shift register, flags and register decode.

## Test plan
Run with `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- **Single byte:** send frame 0xA5 -> STATUS reads 0x11, DATA reads 0xA5, then STATUS reads 0x00.
- **Overrun:** send 5 frames 0x01..0x05 without reading -> count = 4, `ovr` = 1. DATA reads return 0x01..0x04 in order. Writing 0x2 to STATUS clears `ovr`.
- **Framing error:** send 0x3C with stop bit 0 -> `ferr` = 1 and FIFO stays empty. Line held low 40 bits -> no further frames or errors. Release the line and send 0x55 -> 0x55 is received.
- **Glitch:** drive a 4-clock low pulse on idle `rxd` -> FSM returns to IDLE and nothing is pushed.
- **Interrupt:** `irq_en` = 0 with data pending -> `irq` = 0. Write CONTROL = 1 -> `irq` = 1 next cycle. Read the last byte -> `irq` = 0.
- **Reset and coincident events:** assert `reset_n` during data bit 3 -> all reset values; the next full frame 0x7E is received correctly. With the FIFO full, a DATA read coincident with a push -> count stays 4 and `ovr` stays 0.

Source files
------------

// File: rtl/nios_rs232_rx_pkg.sv
// Shared constants for the RS-232 receive slave: register map, STATUS bit
// positions and the receiver FSM state encoding.
package nios_rs232_rx_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int ST_VALID   = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_FERR    = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/nios_rs232_rx_fifo.sv
// Byte-wide synchronous FIFO. A push while full is accepted only when a pop
// frees the head entry in the same cycle; a pop while empty is ignored.
module nios_rs232_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/nios_rs232_rx.sv
// RS-232 8N1 receiver with an Avalon-MM register interface, a receive FIFO
// and a level interrupt for pending data or line errors.
module nios_rs232_rx
  import nios_rs232_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        rxd,
  output logic        irq
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d, irq_en_q, irq_en_d;
  logic          push, ferr_set, timer_zero;
  logic          rd_en, wr_en, pop, status_clr;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_wdata;

  assign unused_wdata = ^writedata[31:3];
  assign timer_zero   = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = RX_START;
          timer_d = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!timer_zero) timer_d = timer_q - TW'(1);
        else if (rx_s_q) state_d = RX_IDLE;
        else begin
          state_d   = RX_DATA;
          timer_d   = FULL_LOAD;
          bit_idx_d = 3'd0;
        end
      end
      RX_DATA: begin
        if (!timer_zero) timer_d = timer_q - TW'(1);
        else begin
          shift_d[bit_idx_q] = rx_s_q;
          timer_d            = FULL_LOAD;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (!timer_zero) timer_d = timer_q - TW'(1);
        else begin
          state_d  = RX_IDLE;
          push     = rx_s_q;
          ferr_set = ~rx_s_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Bus decode; sticky error flags give priority to a new event over a clear.
  always_comb begin
    rd_en      = chipselect & ~read_n;
    wr_en      = chipselect & ~write_n;
    pop        = rd_en & (address == ADDR_DATA);
    status_clr = wr_en & (address == ADDR_STATUS);
    ovr_d      = (ovr_q  & ~(status_clr & writedata[ST_OVR]))  | (push & fifo_full & ~pop);
    ferr_d     = (ferr_q & ~(status_clr & writedata[ST_FERR])) | ferr_set;
    irq_en_d   = irq_en_q;
    if (wr_en && address == ADDR_CONTROL) irq_en_d = writedata[0];
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:    if (!fifo_empty) readdata[7:0] = fifo_dout;
      ADDR_STATUS: begin
        readdata[ST_VALID]                 = ~fifo_empty;
        readdata[ST_OVR]                   = ovr_q;
        readdata[ST_FERR]                  = ferr_q;
        readdata[ST_BUSY]                  = (state_q != RX_IDLE);
        readdata[ST_CNT_LSB +: 5]          = 5'(fifo_count);
      end
      ADDR_CONTROL: readdata[0] = irq_en_q;
      default:      readdata = 32'd0;
    endcase
  end

  assign irq = irq_en_q & (~fifo_empty | ovr_q | ferr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      irq_en_q  <= irq_en_d;
    end
  end

  nios_rs232_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_nios_rs232_rx.sv
// Directed bench for nios_rs232_rx at 16 clocks per bit with a 4-deep FIFO.
module tb_nios_rs232_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        rxd = 1'b1;
  logic        irq;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_status;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs[6];

  nios_rs232_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .rxd        (rxd),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = stop;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    @(posedge clk);
    #1 chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk);
    #1 chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0] = '{8'hA5, 32'h11, 32'hA5};
    vecs[1] = '{8'h00, 32'h11, 32'h00};
    vecs[2] = '{8'hFF, 32'h11, 32'hFF};
    vecs[3] = '{8'h55, 32'h11, 32'h55};
    vecs[4] = '{8'h80, 32'h11, 32'h80};
    vecs[5] = '{8'h01, 32'h11, 32'h01};

    // reset state
    repeat (3) @(posedge clk);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1 check($sformatf("reset_rd%0d", a), readdata, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // single-byte frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, 1'b1);
      bus_read(ADDR_STATUS_L(), rd);
      check($sformatf("vec%0d_status", i), rd, vecs[i].exp_status);
      bus_read(2'd0, rd);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_read);
      bus_read(2'd1, rd);
      check($sformatf("vec%0d_status_after", i), rd, 32'h0);
    end

    // overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    bus_read(2'd1, rd);
    check("ovr_status", rd, 32'h43);
    for (int i = 1; i <= 4; i++) begin
      bus_read(2'd0, rd);
      check($sformatf("ovr_data%0d", i), rd, 32'(i));
    end
    bus_read(2'd0, rd);
    check("ovr_empty_read", rd, 32'h0);
    bus_read(2'd1, rd);
    check("ovr_status_drained", rd, 32'h02);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, rd);
    check("ovr_cleared", rd, 32'h0);

    // framing error and held break
    send_frame(8'h3C, 1'b0);
    bus_read(2'd1, rd);
    check("ferr_status", rd, 32'h04);
    rxd = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    bus_read(2'd1, rd);
    check("break_status", rd, 32'h04);
    #1 rxd = 1'b1;
    repeat (CPB) @(posedge clk);
    send_frame(8'h55, 1'b1);
    bus_read(2'd1, rd);
    check("after_break_status", rd, 32'h15);
    bus_read(2'd0, rd);
    check("after_break_data", rd, 32'h55);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd);
    check("ferr_cleared", rd, 32'h0);

    // glitch
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (2) @(posedge clk);
    bus_read(2'd1, rd);
    check("glitch_busy", rd, 32'h08);
    repeat (20) @(posedge clk);
    bus_read(2'd1, rd);
    check("glitch_idle", rd, 32'h0);

    // interrupt
    send_frame(8'h9C, 1'b1);
    check("irq_disabled", {31'd0, irq}, 32'd0);
    bus_write(2'd2, 32'h1);
    check("irq_enabled", {31'd0, irq}, 32'd1);
    bus_read(2'd2, rd);
    check("control_rd", rd, 32'h1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    check("reserved_rd", rd, 32'h0);
    bus_read(2'd0, rd);
    check("irq_data", rd, 32'h9C);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // reset in the middle of data bit 3, with a byte pending and irq enabled
    send_frame(8'h11, 1'b1);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int b = 0; b < 3; b++) begin
      #1 rxd = b[0] ? 1'b1 : 1'b0;  // 0x7E bits 0..2 = 0,1,1
      if (b == 0) rxd = 1'b0; else rxd = 1'b1;
      repeat (CPB) @(posedge clk);
    end
    #1 rxd = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1 check($sformatf("midreset_rd%0d", a), readdata, 32'd0);
    end
    check("midreset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    bus_read(2'd1, rd);
    check("post_reset_status", rd, 32'h0);
    send_frame(8'h7E, 1'b1);
    bus_read(2'd1, rd);
    check("post_reset_frame_status", rd, 32'h11);
    bus_read(2'd0, rd);
    check("post_reset_frame_data", rd, 32'h7E);

    // full FIFO: pop coincident with the push of a fifth frame
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    bus_read(2'd1, rd);
    check("full_status", rd, 32'h41);
    fork
      send_frame(8'h14, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        #1 rd = readdata;
        @(posedge clk);
        #1 chipselect = 1'b0; read_n = 1'b1;
      end
    join
    check("coincident_data", rd, 32'h10);
    bus_read(2'd1, rd);
    check("coincident_status", rd, 32'h41);
    for (int i = 1; i <= 4; i++) begin
      bus_read(2'd0, rd);
      check($sformatf("coincident_drain%0d", i), rd, 32'h10 + 32'(i));
    end
    bus_read(2'd1, rd);
    check("final_status", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [1:0] ADDR_STATUS_L();
    return 2'd1;
  endfunction

endmodule
